// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch stage: word width, NOP
// encoding, instruction size and the queued fetch entry layout.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ILEN_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction memory address/data, redirect request from
// execute and the valid/ready instruction stream towards decode.
// master = fetch unit side, slave = memory/execute/decode side.
interface ifetch_unit_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_out,
        output inst_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_out,
        input  inst_pc
    );

endinterface

// File: rtl/ifetch_unit_fifo.sv
// ifetch_fifo: synchronous prefetch queue of fetch_entry_t with push, pop,
// flush and occupancy count. DEPTH must be a power of two (2..16) so the
// pointers wrap naturally.
module ifetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic            full;
    logic            do_push;
    logic            do_pop;

    // Qualify requests so an empty pop or a full push can never corrupt state.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        do_pop  = pop && !empty;
        do_push = push && !full;
        head    = mem[rd_ptr];
        count   = count_q;
    end

    // Pointer and occupancy tracking; flush discards every stored entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32I instruction-fetch stage. Owns the fetch PC, drives the
// synchronous instruction memory, queues returned words and hands them to
// decode on a valid/ready handshake. Redirects flush all wrong-path state.
// Optional feature: define IFETCH_BYPASS_EN to forward a returning word
// straight to decode when the queue is empty (one cycle less latency).
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic         clk,
    input  logic         reset,
    ifetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fpc;
    logic            pend;
    logic [XLEN-1:0] pend_pc;

    logic [CW-1:0]   q_count;
    fetch_entry_t    q_head;
    logic            q_empty;
    logic            q_push;
    logic            q_pop;
    fetch_entry_t    push_entry;

    logic [CW:0]     occupancy;
    logic            issue;
    logic            bypass_hit;
    logic            handshake;

    // Issue decision: the in-flight word already owns a slot, and a pop this
    // cycle is deliberately not credited so the queue can never overflow.
    always_comb begin
        occupancy = {1'b0, q_count} + (CW+1)'(pend);
        issue     = !bus.redirect_valid && (occupancy < (CW+1)'(DEPTH));
    end

    // Bypass is only possible when nothing older is waiting in the queue.
    always_comb begin
`ifdef IFETCH_BYPASS_EN
        bypass_hit = q_empty && pend;
`else
        bypass_hit = 1'b0;
`endif
    end

    // Decode-facing outputs: queue head first, then bypassed word, else NOP.
    always_comb begin
        bus.inst_valid = 1'b0;
        bus.inst_out   = NOP_INST;
        bus.inst_pc    = '0;
        if (!q_empty) begin
            bus.inst_valid = 1'b1;
            bus.inst_out   = q_head.inst;
            bus.inst_pc    = q_head.pc;
        end else if (bypass_hit) begin
            bus.inst_valid = 1'b1;
            bus.inst_out   = bus.imem_rdata;
            bus.inst_pc    = pend_pc;
        end
    end

    // Queue control: a redirect drops the in-flight word; a bypassed word
    // that decode takes immediately is never written into the queue.
    always_comb begin
        handshake       = bus.inst_valid && bus.inst_ready;
        q_pop           = handshake && !q_empty;
        q_push          = pend && !bus.redirect_valid && !(bypass_hit && bus.inst_ready);
        push_entry.pc   = pend_pc;
        push_entry.inst = bus.imem_rdata;
        bus.imem_addr   = fpc;
    end

    // Fetch PC and outstanding-request tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc     <= RESET_PC;
            pend    <= 1'b0;
            pend_pc <= '0;
        end else if (bus.redirect_valid) begin
            fpc  <= align_pc(bus.redirect_pc);
            pend <= 1'b0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_pc <= fpc;
                fpc     <= fpc + XLEN'(ILEN_BYTES);
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .flush     (bus.redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit: two instances (RESET_PC 0 and
// RESET_PC near the top of the address space), each fed by a synchronous
// memory model returning 32'h1000_0000 + word index.
module tb_ifetch_unit;
    import riscv_pkg::*;

`ifdef IFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ifetch_unit_if bus0 ();
    ifetch_unit_if bus1 ();

    ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_hi (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    // Synchronous instruction memories: word for last cycle's address.
    always @(posedge clk) begin
        bus0.imem_rdata <= 32'h1000_0000 + (bus0.imem_addr >> 2);
        bus1.imem_rdata <= 32'h1000_0000 + (bus1.imem_addr >> 2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        bus0.redirect_valid = 1'b0;
        bus0.redirect_pc    = '0;
        bus0.inst_ready     = 1'b1;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc    = '0;
        bus1.inst_ready     = 1'b1;

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus0.inst_valid), 32'd0);
        check("rst_out",   bus0.inst_out,        32'h0000_0013);
        check("rst_pc",    bus0.inst_pc,         32'h0);
        check("rst_addr",  bus0.imem_addr,       32'h0);
        check("rst_addr_hi", bus1.imem_addr,     32'hFFFF_FFF8);
        check("rst_count", 32'(dut.q_count),     32'd0);

        // ---- streaming from reset, ready high ----
        reset = 1'b0;
        @(negedge clk);
        check("strm_addr1",    bus0.imem_addr, 32'h4);
        check("strm_addr1_hi", bus1.imem_addr, 32'hFFFF_FFFC);
        check("strm_valid1",   32'(bus0.inst_valid), 32'(BYP));
        if (BYP == 0) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("strm_valid", 32'(bus0.inst_valid), 32'd1);
            check("strm_pc",    bus0.inst_pc,  32'(4 * i));
            check("strm_inst",  bus0.inst_out, 32'h1000_0000 + 32'(i));
            if (i < 3) begin
                check("wrap_pc", bus1.inst_pc, 32'hFFFF_FFF8 + 32'(4 * i));
            end
            @(negedge clk);
        end

        // ---- stall: queue fills, fetch stops, release without gap ----
        reset = 1'b1;
        bus0.inst_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_count", 32'(dut.q_count), 32'd4);
        check("stall_addr",  bus0.imem_addr,   32'h10);
        check("stall_valid", 32'(bus0.inst_valid), 32'd1);
        bus0.inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("rel_valid", 32'(bus0.inst_valid), 32'd1);
            check("rel_pc",    bus0.inst_pc, 32'(4 * i));
            @(negedge clk);
        end

        // ---- redirect with 3 queued entries and one in flight ----
        reset = 1'b1;
        bus0.inst_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rd_pre_count", 32'(dut.q_count), 32'd3);
        check("rd_pre_pend",  32'(dut.pend),    32'd1);
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        bus0.redirect_valid = 1'b0;
        bus0.inst_ready     = 1'b1;
        check("rd_addr",  bus0.imem_addr, 32'h100);
        check("rd_valid1", 32'(bus0.inst_valid), 32'd0);
        check("rd_count", 32'(dut.q_count), 32'd0);
        @(negedge clk);
        check("rd_valid2", 32'(bus0.inst_valid), 32'(BYP));
        if (BYP == 0) @(negedge clk);
        check("rd_new_valid", 32'(bus0.inst_valid), 32'd1);
        check("rd_new_pc",    bus0.inst_pc,  32'h100);
        check("rd_new_inst",  bus0.inst_out, 32'h1000_0040);
        @(negedge clk);
        check("rd_next_pc",   bus0.inst_pc,  32'h104);

        // ---- misaligned redirect coinciding with a handshake ----
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc    = 32'h0000_0203;
        @(negedge clk);
        bus0.redirect_valid = 1'b0;
        check("rh_addr",   bus0.imem_addr, 32'h200);
        check("rh_valid1", 32'(bus0.inst_valid), 32'd0);
        @(negedge clk);
        check("rh_valid2", 32'(bus0.inst_valid), 32'(BYP));
        if (BYP == 0) @(negedge clk);
        check("rh_pc",   bus0.inst_pc,  32'h200);
        check("rh_inst", bus0.inst_out, 32'h1000_0080);
        @(negedge clk);
        check("rh_pc2",  bus0.inst_pc,  32'h204);

        // ---- half-cycle asynchronous reset mid-stream ----
        #1 reset = 1'b1;
        #1;
        check("ar_valid", 32'(bus0.inst_valid), 32'd0);
        check("ar_out",   bus0.inst_out,  32'h0000_0013);
        check("ar_pc",    bus0.inst_pc,   32'h0);
        check("ar_addr",  bus0.imem_addr, 32'h0);
        check("ar_count", 32'(dut.q_count), 32'd0);
        #2 reset = 1'b0;
        @(negedge clk);
        check("ar_addr1",  bus0.imem_addr, 32'h4);
        check("ar_valid1", 32'(bus0.inst_valid), 32'(BYP));
        if (BYP == 0) @(negedge clk);
        check("ar_rs_pc",   bus0.inst_pc,  32'h0);
        check("ar_rs_inst", bus0.inst_out, 32'h1000_0000);
        @(negedge clk);
        check("ar_rs_pc2",  bus0.inst_pc,  32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage for the single-issue RV32I core: owns the fetch PC, drives the address of the synchronous instruction memory `inst_mem`, and buffers returned instruction words in a small prefetch queue. It sits directly upstream of decode, presenting one instruction per cycle on a valid/ready handshake. It accepts redirects (branch, jump, trap) from execute and discards wrong-path words.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.
- `DEPTH`, 4: prefetch queue entries; power of two, 2..16.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_addr` out 32: address to `inst_mem.addr`; equals internal fetch PC.
- `imem_rdata` in 32: `inst_mem.read_data`; word for the address presented in the previous cycle.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch PC; bits [1:0] ignored (forced 0).
- `inst_valid` out 1: `inst_out`/`inst_pc` hold a valid instruction.
- `inst_ready` in 1: decode accepts when `inst_valid & inst_ready`.
- `inst_out` out 32: instruction word.
- `inst_pc` out 32: address of `inst_out`.

## Operation
- State: `fpc` (fetch PC), `pend` (1 = response due next cycle), `pend_pc`, queue with `count`.
- Issue in a cycle iff `!redirect_valid && count + pend < DEPTH`, counting a pop this cycle as freeing nothing. Issue sets `pend`<=1, `pend_pc`<=`fpc`, and `fpc`<=`fpc`+4. Otherwise `pend`<=0 and `fpc` holds.
- Response: when `pend`=1, {`pend_pc`,`imem_rdata`} is pushed at end of cycle; with `pend`=0, `imem_rdata` is ignored.
- Output: head of queue; pop on handshake.
- Redirect: the handshake in the same cycle completes normally. Then the queue is emptied, `pend`<=0 (in-flight word dropped), and `fpc`<=`{redirect_pc[31:2],2'b00}`.
- `fpc` increment wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- When `inst_valid`=0: `inst_out`=32'h0000_0013 (NOP), `inst_pc`=0.
- Overflow is impossible by the issue rule. Push and pop in the same cycle leave `count` unchanged.

## Timing
- Reset values: `fpc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `pend`=0, `count`=0, `inst_valid`=0, `inst_out`=NOP, `inst_pc`=0.
- Reset asserted mid-operation clears all state immediately (async). The first issue is in the first cycle with `reset` low.
- Fetch latency: address in cycle t, word visible on `inst_out` in cycle t+2 (t+1 with bypass).
- Redirect in cycle r: `imem_addr`=`redirect_pc` in r+1; first new instruction valid in r+3 (r+2 with bypass). No old-path word is visible after r.
- Throughput: 1 instruction/cycle sustained with `inst_ready` held high.
- Stall: with `inst_ready` low, the queue fills to `DEPTH` and then issue stops. `imem_addr` holds the next unfetched PC.

## Configuration
- `IFETCH_BYPASS_EN` defined: if the queue is empty and `pend`=1, `inst_valid`=1 and outputs are driven directly from {`pend_pc`,`imem_rdata`}. The word is pushed only if not accepted that cycle.
- Undefined: all responses pass through the queue. This adds one cycle of latency and gives a fully registered output path.

## Structure
- Shared package `riscv_pkg`: `XLEN`=32, `NOP_INST`=32'h0000_0013, `ILEN_BYTES`=4, and the `fetch_entry_t` struct {pc, inst}.
- Sub-module `ifetch_fifo`: synchronous FIFO of `fetch_entry_t`, parameter `DEPTH`, with push/pop/flush/count and async reset.
- Top level holds `fpc`, `pend`, and the issue and redirect logic.

## Test plan
- Reset, `RESET_PC`=0, memory word i = 32'h1000_0000+i, `inst_ready`=1 -> `inst_pc` 0,4,8,... one per cycle, first valid 2 cycles after reset deassert (1 with bypass).
- `inst_ready`=0 for 10 cycles -> `count` saturates at 4, `imem_addr` holds 16. Release -> pcs 0..12 then 16 delivered without gap or duplicate.
- Redirect to 32'h0000_0100 while 3 entries are queued and `pend`=1 -> no pc 0x0..0x14 after redirect, next `inst_pc`=0x100 at r+3.
- Redirect with `redirect_pc`=32'h0000_0203 coinciding with a handshake -> head consumed once, next `inst_pc`=0x200.
- `RESET_PC`=32'hFFFF_FFF8 -> `inst_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` for half a cycle mid-stream -> `inst_valid` falls immediately, `inst_out`=NOP, fetch restarts at `RESET_PC`.
